// File: rtl/oled_pkg.sv
// oled_pkg: FSM state encoding, SSD1306 opcodes and the power-on init command table
// shared by the OLED SPI scheduler and its init ROM.
package oled_pkg;

  typedef enum logic [2:0] {
    PWR_HI1,
    PWR_LO,
    PWR_HI2,
    INIT,
    IDLE,
    CMD,
    FB_FETCH,
    FB_SEND
  } sched_state_t;

  localparam int FB_AW      = 10;
  localparam int INIT_LEN   = 23;
  localparam int INIT_IDX_W = $clog2(INIT_LEN + 1);

  localparam logic [7:0] OP_DISPLAY_OFF  = 8'hAE;
  localparam logic [7:0] OP_DISPLAY_ON   = 8'hAF;
  localparam logic [7:0] OP_SET_CONTRAST = 8'h81;
  localparam logic [7:0] OP_SET_CLK_DIV  = 8'hD5;
  localparam logic [7:0] OP_SET_MUX      = 8'hA8;
  localparam logic [7:0] OP_SET_OFFSET   = 8'hD3;
  localparam logic [7:0] OP_CHARGE_PUMP  = 8'h8D;
  localparam logic [7:0] OP_ADDR_MODE    = 8'h20;
  localparam logic [7:0] OP_SEG_REMAP    = 8'hA1;
  localparam logic [7:0] OP_COM_SCAN_DEC = 8'hC8;
  localparam logic [7:0] OP_COM_PINS     = 8'hDA;
  localparam logic [7:0] OP_PRECHARGE    = 8'hD9;
  localparam logic [7:0] OP_VCOMH        = 8'hDB;
  localparam logic [7:0] OP_RESUME_RAM   = 8'hA4;

  // Panel stays dark until the final display-on, after charge pump and addressing are set up.
  localparam logic [7:0] INIT_CMDS [INIT_LEN] = '{
    OP_DISPLAY_OFF,
    OP_SET_CONTRAST, 8'h7F,
    OP_SET_CLK_DIV,  8'h80,
    OP_SET_MUX,      8'h3F,
    OP_SET_OFFSET,   8'h00,
    OP_CHARGE_PUMP,  8'h14,
    OP_ADDR_MODE,    8'h00,
    OP_SEG_REMAP,
    OP_COM_SCAN_DEC,
    OP_COM_PINS,     8'h12,
    OP_PRECHARGE,    8'hF1,
    OP_VCOMH,        8'h40,
    OP_RESUME_RAM,
    OP_DISPLAY_ON
  };

endpackage

// File: rtl/oled_init_rom.sv
// oled_init_rom: combinational index-to-byte lookup of the SSD1306 init stream.
module oled_init_rom
  import oled_pkg::*;
(
  input  logic [INIT_IDX_W-1:0] idx,
  output logic [7:0]            data
);

  always_comb begin
    data = 8'h00;
    if (int'(idx) < INIT_LEN) data = INIT_CMDS[idx];
  end

endmodule

// File: rtl/oled_spi_scheduler.sv
// oled_spi_scheduler: panel power sequencing, init stream, host commands and framebuffer refresh
// onto the shared oled_spi_tx byte port. Define OLED_SCHED_AUTOREFRESH_EN for back-to-back frames.
module oled_spi_scheduler
  import oled_pkg::*;
#(
  parameter int STARTUP_WAIT = 10000000,
  parameter int FB_BYTES     = 1024
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  output logic             oled_reset_o,
  output logic             tx_valid_o,
  input  logic             tx_ready_i,
  output logic [7:0]       tx_data_o,
  output logic             tx_dc_o,
  output logic             fb_rd_en_o,
  output logic [FB_AW-1:0] fb_rd_addr_o,
  input  logic [7:0]       fb_rd_data_i,
  input  logic             refresh_req_i,
  input  logic             cmd_valid_i,
  input  logic [7:0]       cmd_data_i,
  output logic             cmd_ready_o,
  output logic             init_done_o,
  output logic             frame_done_o
);

  localparam int CW = $clog2(3 * STARTUP_WAIT + 1);
  localparam logic [CW-1:0] END_HI1 = CW'(STARTUP_WAIT - 1);
  localparam logic [CW-1:0] END_LO  = CW'(2 * STARTUP_WAIT - 1);
  localparam logic [CW-1:0] END_HI2 = CW'(3 * STARTUP_WAIT - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(3 * STARTUP_WAIT);

  sched_state_t          state, state_next;
  logic [CW-1:0]         wait_cnt;
  logic [INIT_IDX_W-1:0] init_idx;
  logic [FB_AW-1:0]      fb_addr;
  logic [7:0]            cmd_byte, fb_byte, rom_byte;
  logic                  fetch_d, pending, init_done, frame_done;
  logic                  tx_fire, last_init, last_fb, go_frame, pending_set;

  oled_init_rom u_rom (
    .idx  (init_idx),
    .data (rom_byte)
  );

  assign tx_fire   = tx_valid_o && tx_ready_i;
  assign last_init = (state == INIT) && tx_fire && (init_idx == INIT_IDX_W'(INIT_LEN - 1));
  assign last_fb   = (state == FB_SEND) && tx_fire && (fb_addr == FB_AW'(FB_BYTES - 1));
  assign go_frame  = (state == IDLE) && !cmd_valid_i && pending;

`ifdef OLED_SCHED_AUTOREFRESH_EN
  assign pending_set = last_init || last_fb;
`else
  assign pending_set = refresh_req_i;
`endif

  assign fb_rd_addr_o = fb_addr;
  assign init_done_o  = init_done;
  assign frame_done_o = frame_done;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state <= PWR_HI1;
    else           state <= state_next;
  end

  // Outputs decode from state so an async reset returns them to idle values at once.
  always_comb begin
    state_next   = state;
    oled_reset_o = 1'b1;
    tx_valid_o   = 1'b0;
    tx_data_o    = 8'h00;
    tx_dc_o      = 1'b0;
    fb_rd_en_o   = 1'b0;
    cmd_ready_o  = 1'b0;
    case (state)
      PWR_HI1: if (wait_cnt == END_HI1) state_next = PWR_LO;
      PWR_LO: begin
        oled_reset_o = 1'b0;
        if (wait_cnt == END_LO) state_next = PWR_HI2;
      end
      PWR_HI2: if (wait_cnt == END_HI2) state_next = INIT;
      INIT: begin
        tx_valid_o = 1'b1;
        tx_data_o  = rom_byte;
        if (last_init) state_next = IDLE;
      end
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i)  state_next = CMD;
        else if (pending) state_next = FB_FETCH;
      end
      CMD: begin
        tx_valid_o = 1'b1;
        tx_data_o  = cmd_byte;
        if (tx_ready_i) state_next = IDLE;
      end
      FB_FETCH: begin
        fb_rd_en_o = 1'b1;
        state_next = FB_SEND;
      end
      FB_SEND: begin
        tx_valid_o = 1'b1;
        tx_dc_o    = 1'b1;
        // RAM data is only guaranteed on the first cycle; later stall cycles replay the held copy.
        tx_data_o  = fetch_d ? fb_rd_data_i : fb_byte;
        if (tx_ready_i) state_next = last_fb ? IDLE : FB_FETCH;
      end
      default: state_next = PWR_HI1;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wait_cnt   <= '0;
      init_idx   <= '0;
      fb_addr    <= '0;
      cmd_byte   <= 8'h00;
      fb_byte    <= 8'h00;
      fetch_d    <= 1'b0;
      pending    <= 1'b0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + CW'(1);
      if (state == INIT && tx_fire) init_idx <= init_idx + INIT_IDX_W'(1);
      if (state == FB_SEND && tx_fire) fb_addr <= last_fb ? '0 : fb_addr + FB_AW'(1);
      if (state == IDLE && cmd_valid_i) cmd_byte <= cmd_data_i;
      fetch_d <= (state == FB_FETCH);
      if (fetch_d) fb_byte <= fb_rd_data_i;
      if (pending_set)   pending <= 1'b1;
      else if (go_frame) pending <= 1'b0;
      if (last_init) init_done <= 1'b1;
      frame_done <= last_fb;
    end
  end

endmodule

// File: tb/tb_oled_spi_scheduler.sv
// tb_oled_spi_scheduler: power-sequence vector table, then init/command/frame streams with
// random tx stalls compared against a byte-stream model built from the command/refresh history.
`timescale 1ns/1ps
module tb_oled_spi_scheduler;

  localparam int SW     = 4;
  localparam int FB     = 1024;
  localparam int INIT_N = 23;
  localparam logic [14:0] W_RST = 15'h4000;

  localparam logic [7:0] INIT_REF [INIT_N] = '{
    8'hAE, 8'h81, 8'h7F, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h8D, 8'h14, 8'h20,
    8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hAF
  };

  typedef struct {
    logic        rst_n;
    logic [14:0] exp;
  } pwr_vec_t;

  logic       clk = 1'b0, reset_ni = 1'b0, tx_ready_i = 1'b0;
  logic       refresh_req_i = 1'b0, cmd_valid_i = 1'b0;
  logic [7:0] fb_rd_data_i = 8'h00, cmd_data_i = 8'h00;
  logic       oled_reset_o, tx_valid_o, tx_dc_o, fb_rd_en_o, cmd_ready_o, init_done_o, frame_done_o;
  logic [7:0] tx_data_o;
  logic [9:0] fb_rd_addr_o;

  int         errors = 0, checks = 0;
  int         ready_mode = 0;
  int         data_cnt = 0, frame_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [9:0] prev_word = '0;
  logic [8:0] tx_log[$];
  logic [8:0] exp_q[$];
  logic [7:0] fbmem [FB];
  pwr_vec_t   pwr_tbl [3*SW+2];

  oled_spi_scheduler #(.STARTUP_WAIT(SW), .FB_BYTES(FB)) dut (
    .clk_i         (clk),
    .reset_ni      (reset_ni),
    .oled_reset_o  (oled_reset_o),
    .tx_valid_o    (tx_valid_o),
    .tx_ready_i    (tx_ready_i),
    .tx_data_o     (tx_data_o),
    .tx_dc_o       (tx_dc_o),
    .fb_rd_en_o    (fb_rd_en_o),
    .fb_rd_addr_o  (fb_rd_addr_o),
    .fb_rd_data_i  (fb_rd_data_i),
    .refresh_req_i (refresh_req_i),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_data_i    (cmd_data_i),
    .cmd_ready_o   (cmd_ready_o),
    .init_done_o   (init_done_o),
    .frame_done_o  (frame_done_o)
  );

  always #5 clk = ~clk;

  // Synchronous-read framebuffer; returns junk whenever no read was issued the cycle before.
  always @(posedge clk) fb_rd_data_i <= fb_rd_en_o ? fbmem[fb_rd_addr_o] : 8'($urandom);

  function automatic logic [14:0] outWord();
    return {oled_reset_o, tx_valid_o, tx_dc_o, tx_data_o, fb_rd_en_o, cmd_ready_o, init_done_o, frame_done_o};
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Drives tx_ready each negedge, then logs handshakes and checks stalled bytes are held.
  always @(negedge clk) begin
    case (ready_mode)
      0:       tx_ready_i = 1'b0;
      1:       tx_ready_i = 1'b1;
      default: tx_ready_i = ($urandom_range(0, 2) != 0);
    endcase
    #1;
    if (reset_ni) begin
      if (prev_stall) checkOutput("stall_hold", {tx_valid_o, tx_dc_o, tx_data_o}, prev_word);
      if (tx_valid_o && tx_ready_i) begin
        tx_log.push_back({tx_dc_o, tx_data_o});
        if (tx_dc_o) data_cnt++;
      end
      prev_stall = tx_valid_o && !tx_ready_i;
      prev_word  = {1'b1, tx_dc_o, tx_data_o};
      if (frame_done_o) frame_cnt++;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic applyStimulus();
    for (int i = 0; i < 3*SW+2; i++) begin
      @(negedge clk);
      reset_ni = pwr_tbl[i].rst_n;
      #2;
      checkOutput($sformatf("pwr[%0d]", i), outWord(), pwr_tbl[i].exp);
      if (i == 0) checkOutput("reset_fb_addr", fb_rd_addr_o, 0);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic waitInit();
    int n = 0;
    while (!init_done_o && n < 1000) begin @(negedge clk); #2; n++; end
    checkOutput("init_done_seen", init_done_o, 1);
    checkOutput("init_done_after_last_byte", tx_log.size(), INIT_N);
  endtask

  task automatic waitFrames(input int target);
    int n = 0;
    while (frame_cnt < target && n < 6000) begin @(negedge clk); #2; n++; end
    checkOutput("frame_done_timeout", frame_cnt >= target, 1);
  endtask

  task automatic waitData(input int target);
    int n = 0;
    while (data_cnt < target && n < 3000) begin @(negedge clk); #2; n++; end
    checkOutput("data_count_timeout", data_cnt >= target, 1);
  endtask

  task automatic waitLog(input int target);
    int n = 0;
    while (tx_log.size() < target && n < 200) begin @(negedge clk); #2; n++; end
    checkOutput("log_timeout", tx_log.size() >= target, 1);
  endtask

  task automatic pushFrame();
    for (int i = 0; i < FB; i++) exp_q.push_back({1'b1, fbmem[i]});
  endtask

  task automatic pushInit();
    for (int i = 0; i < INIT_N; i++) exp_q.push_back({1'b0, INIT_REF[i]});
  endtask

  task automatic compareLog(input string name);
    int bad = -1;
    checkOutput({name, "_len"}, tx_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++)
      if (bad < 0 && tx_log[i] != exp_q[i]) bad = i;
    if (bad >= 0)
      checkOutput($sformatf("%s_first_bad_idx(got %h want %h)", name, tx_log[bad], exp_q[bad]), bad, -1);
    else
      checkOutput({name, "_first_bad_idx"}, bad, -1);
    tx_log.delete();
    exp_q.delete();
    data_cnt = 0;
  endtask

  task automatic pulseRefresh();
    @(negedge clk);
    refresh_req_i = 1'b1;
    @(negedge clk);
    refresh_req_i = 1'b0;
  endtask

  // Issued from IDLE: optional command byte and/or refresh pulse in the same cycle.
  task automatic issueOp(input bit do_cmd, input bit do_ref, input logic [7:0] b, input string name);
    int f0 = frame_cnt;
    int n  = 0;
    @(negedge clk);
    cmd_valid_i   = do_cmd;
    cmd_data_i    = b;
    refresh_req_i = do_ref;
    #2;
    if (do_cmd) begin
      while (!cmd_ready_o && n < 200) begin @(negedge clk); #2; refresh_req_i = 1'b0; n++; end
      checkOutput({name, "_cmd_ready"}, cmd_ready_o, 1);
    end
    @(negedge clk);
    cmd_valid_i   = 1'b0;
    refresh_req_i = 1'b0;
    if (do_cmd) exp_q.push_back({1'b0, b});
    if (do_ref) begin
      pushFrame();
      waitFrames(f0 + 1);
    end else begin
      waitLog(exp_q.size());
    end
    waitCycles(20);
    checkOutput({name, "_frame_pulses"}, frame_cnt - f0, int'(do_ref));
    compareLog(name);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int f0;
    for (int i = 0; i < FB; i++) fbmem[i] = 8'(i);
    pwr_tbl[0] = '{1'b0, W_RST};
    for (int c = 0; c < 3*SW; c++)
      pwr_tbl[c+1] = '{1'b1, (c >= SW && c < 2*SW) ? 15'h0000 : W_RST};
    pwr_tbl[3*SW+1] = '{1'b1, {1'b1, 1'b1, 1'b0, 8'hAE, 4'b0000}};

    ready_mode = 0;
    applyStimulus();
    ready_mode = 2;
    waitInit();
    waitCycles(5);
    pushInit();
    compareLog("init");

`ifdef OLED_SCHED_AUTOREFRESH_EN
    f0 = frame_cnt;
    waitFrames(f0 + 2);
    checkOutput("auto_second_frame", frame_cnt - f0 >= 2, 1);
`else
    issueOp(1'b0, 1'b1, 8'h00, "frame1");

    f0 = frame_cnt;
    pulseRefresh();
    waitData(100);
    pulseRefresh();
    cmd_valid_i = 1'b1;
    cmd_data_i  = 8'hA7;
    #2;
    begin
      int n = 0;
      while (!cmd_ready_o && n < 5000) begin @(negedge clk); #2; n++; end
    end
    checkOutput("mid_cmd_accepted", cmd_ready_o, 1);
    checkOutput("mid_cmd_held_until_frame_done", frame_cnt - f0, 1);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    waitFrames(f0 + 2);
    waitCycles(20);
    checkOutput("mid_cmd_frame_pulses", frame_cnt - f0, 2);
    pushFrame();
    exp_q.push_back({1'b0, 8'hA7});
    pushFrame();
    compareLog("cmd_mid_frame");

    issueOp(1'b1, 1'b1, 8'h3C, "cmd_and_refresh");

    for (int i = 0; i < FB; i++) fbmem[i] = 8'($urandom);
    for (int k = 0; k < 4; k++) begin
      int op = $urandom_range(0, 2);
      issueOp(op != 1, op != 0, 8'($urandom), $sformatf("rand%0d", k));
    end

    pulseRefresh();
    waitData(500);
    @(negedge clk);
    reset_ni = 1'b0;
    #1;
    checkOutput("async_reset_outputs", outWord(), W_RST);
    checkOutput("async_reset_fb_addr", fb_rd_addr_o, 0);
    tx_log.delete();
    exp_q.delete();
    data_cnt = 0;
    ready_mode = 0;
    applyStimulus();
    ready_mode = 2;
    waitInit();
    waitCycles(5);
    pushInit();
    compareLog("reinit");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
